flow_export_engine: RTL and testbench

//  Downstream neighbour of the flow create/update stage. Serves its export_now/export_this

---
 rtl/flow_export_engine_if.sv | 32 +++
 rtl/flow_export_engine.sv | 209 ++++++++++++++++++++
 tb/tb_flow_export_engine.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_export_engine_if.sv
// -----------------------------------------------------------------------------
// flow_export_engine_if
//   AXI-Stream record channel between the flow export engine and its sink.
//   Ports (signals):
//     tdata   32  record word
//     tvalid   1  record word valid
//     tready   1  sink ready
//     tlast    1  last word of an 8-word record
//   Modports:
//     master  engine side (drives tdata/tvalid/tlast, samples tready)
//     slave   sink side   (samples tdata/tvalid/tlast, drives tready)
// -----------------------------------------------------------------------------
interface flow_export_engine_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/flow_export_engine.sv
// -----------------------------------------------------------------------------
// flow_export_engine
//   Serves export requests from the flow create/update stage and sweeps the
//   flow cache for inactive flows. Each selected entry is read over BRAM
//   port B, streamed as an 8-word AXI-Stream record, then cleared to zero.
//   Requests are acknowledged with a one-cycle flow_exported_ok pulse.
//
//   Ports:
//     ACLK, ARESETN            clock, asynchronous active-low reset
//     export_now/export_this   level request + cache index from create stage
//     flow_exported_ok         1-cycle pulse: requested entry exported+cleared
//     current_time             free-running timestamp
//     sweep_enable             allow the inactive-timeout sweep when idle
//     enb/web/addrb/dib/dob    BRAM port B (dob has 1-cycle read latency)
//     m_axis                   record stream (master modport)
//     exported_flow_counter    total records sent, wraps at 2^32
//
//   Entry layout: [240] valid, [239:208] src_ip, [207:176] dst_ip,
//   [175:160] src_port, [159:144] dst_port, [143:136] protocol,
//   [135:128] tcp_flags, [127:96] first_ts, [95:64] last_ts,
//   [63:32] pkts, [31:0] bytes.
// -----------------------------------------------------------------------------
module flow_export_engine #(
   parameter logic [31:0] INACTIVE_TIMEOUT = 32'd15000,
   parameter int unsigned ADDR_W           = 12
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  export_now,
   input  logic [ADDR_W-1:0]     export_this,
   output logic                  flow_exported_ok,
   input  logic [31:0]           current_time,
   input  logic                  sweep_enable,
   output logic                  enb,
   output logic                  web,
   output logic [ADDR_W-1:0]     addrb,
   output logic [240:0]          dib,
   input  logic [240:0]          dob,
   flow_export_engine_if.master  m_axis,
   output logic [31:0]           exported_flow_counter
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_LATCH    = 3'd2,
      ST_CHECK    = 3'd3,
      ST_SEND     = 3'd4,
      ST_CLEAR    = 3'd5,
      ST_ACK      = 3'd6,
      ST_COOLDOWN = 3'd7
   } state_t;

   state_t              state_q;
   logic                src_req_q;     // 1 = serving a request, 0 = sweep
   logic [ADDR_W-1:0]   sweep_ptr_q;
   logic [240:0]        rec_q;
   logic [2:0]          word_idx_q;
   logic                enb_q;
   logic                web_q;
   logic [ADDR_W-1:0]   addrb_q;
   logic                ok_q;
   logic                tvalid_q;
   logic [31:0]         tdata_q;
   logic                tlast_q;
   logic [31:0]         cnt_q;

   // Select record word idx from the entry body (valid bit excluded).
   function automatic logic [31:0] rec_word(input logic [239:0] body,
                                            input logic [2:0]   idx);
      logic [31:0] w;
      case (idx)
         3'd0:    w = body[239:208];
         3'd1:    w = body[207:176];
         3'd2:    w = body[175:144];
         3'd3:    w = {body[143:128], 16'h0000};
         3'd4:    w = body[127:96];
         3'd5:    w = body[95:64];
         3'd6:    w = body[63:32];
         3'd7:    w = body[31:0];
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   // Inactive test; modulo-2^32 subtraction keeps it correct across time wrap.
   function automatic logic flow_expired(input logic        valid,
                                         input logic [31:0] last_ts,
                                         input logic [31:0] now);
      logic [31:0] age;
      age = now - last_ts;
      return valid & (age > INACTIVE_TIMEOUT);
   endfunction

   // Export FSM with all outputs registered.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= ST_IDLE;
         src_req_q   <= 1'b0;
         sweep_ptr_q <= '0;
         rec_q       <= 241'b0;
         word_idx_q  <= 3'd0;
         enb_q       <= 1'b0;
         web_q       <= 1'b0;
         addrb_q     <= '0;
         ok_q        <= 1'b0;
         tvalid_q    <= 1'b0;
         tdata_q     <= 32'h0000_0000;
         tlast_q     <= 1'b0;
         cnt_q       <= 32'h0000_0000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // A pending request always wins over the sweep.
               if (export_now) begin
                  addrb_q   <= export_this;
                  src_req_q <= 1'b1;
                  enb_q     <= 1'b1;
                  state_q   <= ST_READ;
               end else if (sweep_enable) begin
                  addrb_q   <= sweep_ptr_q;
                  src_req_q <= 1'b0;
                  enb_q     <= 1'b1;
                  state_q   <= ST_READ;
               end else begin
                  state_q   <= ST_IDLE;
               end
            end
            ST_READ: begin
               enb_q   <= 1'b0;
               state_q <= ST_LATCH;
            end
            ST_LATCH: begin
               rec_q   <= dob;
               state_q <= ST_CHECK;
            end
            ST_CHECK: begin
               // Requests are exported regardless of the valid bit.
               if (src_req_q || flow_expired(rec_q[240], rec_q[95:64], current_time)) begin
                  tvalid_q   <= 1'b1;
                  tdata_q    <= rec_word(rec_q[239:0], 3'd0);
                  tlast_q    <= 1'b0;
                  word_idx_q <= 3'd0;
                  state_q    <= ST_SEND;
               end else begin
                  sweep_ptr_q <= sweep_ptr_q + ADDR_W'(1'b1);
                  state_q     <= ST_IDLE;
               end
            end
            ST_SEND: begin
               // Word only advances on a handshake; held stable otherwise.
               if (m_axis.tready) begin
                  if (word_idx_q == 3'd7) begin
                     tvalid_q <= 1'b0;
                     tlast_q  <= 1'b0;
                     tdata_q  <= 32'h0000_0000;
                     enb_q    <= 1'b1;
                     web_q    <= 1'b1;
                     state_q  <= ST_CLEAR;
                  end else begin
                     word_idx_q <= word_idx_q + 3'd1;
                     tdata_q    <= rec_word(rec_q[239:0], word_idx_q + 3'd1);
                     tlast_q    <= (word_idx_q == 3'd6);
                  end
               end
            end
            ST_CLEAR: begin
               enb_q <= 1'b0;
               web_q <= 1'b0;
               cnt_q <= cnt_q + 32'd1;
               if (src_req_q) begin
                  ok_q    <= 1'b1;
                  state_q <= ST_ACK;
               end else begin
                  sweep_ptr_q <= sweep_ptr_q + ADDR_W'(1'b1);
                  state_q     <= ST_IDLE;
               end
            end
            ST_ACK: begin
               ok_q    <= 1'b0;
               state_q <= ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
               // export_now is still high here; the create stage drops it now.
               state_q <= ST_IDLE;
            end
            default: begin
               enb_q    <= 1'b0;
               web_q    <= 1'b0;
               ok_q     <= 1'b0;
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign enb                   = enb_q;
   assign web                   = web_q;
   assign addrb                 = addrb_q;
   assign dib                   = 241'b0;
   assign flow_exported_ok      = ok_q;
   assign exported_flow_counter = cnt_q;
   assign m_axis.tvalid         = tvalid_q;
   assign m_axis.tdata          = tdata_q;
   assign m_axis.tlast          = tlast_q;

endmodule

// File: tb/tb_flow_export_engine.sv
`timescale 1ns/1ps
module tb_flow_export_engine;

   typedef struct packed {
      logic        v;
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [7:0]  proto;
      logic [7:0]  flags;
      logic [31:0] first_ts;
      logic [31:0] last_ts;
      logic [31:0] pkts;
      logic [31:0] bytes;
   } flow_t;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          export_now;
   logic [11:0]   export_this;
   logic          flow_exported_ok;
   logic [31:0]   current_time;
   logic          sweep_enable;
   logic          enb;
   logic          web;
   logic [11:0]   addrb;
   logic [240:0]  dib;
   logic [240:0]  dob = 241'b0;
   logic [31:0]   exported_flow_counter;
   logic          toggle_mode;
   logic          tgl = 1'b0;

   logic [240:0]  mem [0:4095];

   flow_export_engine_if axis ();

   flow_export_engine #(.INACTIVE_TIMEOUT(32'd15000), .ADDR_W(12)) dut (
      .ACLK                  (ACLK),
      .ARESETN               (ARESETN),
      .export_now            (export_now),
      .export_this           (export_this),
      .flow_exported_ok      (flow_exported_ok),
      .current_time          (current_time),
      .sweep_enable          (sweep_enable),
      .enb                   (enb),
      .web                   (web),
      .addrb                 (addrb),
      .dib                   (dib),
      .dob                   (dob),
      .m_axis                (axis),
      .exported_flow_counter (exported_flow_counter)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) tgl <= ~tgl;
   assign axis.tready = toggle_mode ? tgl : 1'b1;

   // BRAM port B model: read-first, one-cycle read latency.
   always @(posedge ACLK) begin
      if (enb) begin
         if (web) mem[addrb] <= dib;
         dob <= mem[addrb];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [32:0] exp_word(input flow_t f, input int k);
      case (k)
         0: return {1'b0, f.src_ip};
         1: return {1'b0, f.dst_ip};
         2: return {1'b0, f.src_port, f.dst_port};
         3: return {1'b0, f.proto, f.flags, 16'h0000};
         4: return {1'b0, f.first_ts};
         5: return {1'b0, f.last_ts};
         6: return {1'b0, f.pkts};
         7: return {1'b1, f.bytes};
         default: return 33'h0;
      endcase
   endfunction

   function automatic bit model_exports(input flow_t f, input logic [31:0] now);
      longint age;
      age = longint'(now) - longint'(f.last_ts);
      if (age < 0) age = age + 64'sh1_0000_0000;
      return f.v && (age > 15000);
   endfunction

   function automatic flow_t mk_flow(input bit v, input logic [31:0] last, input logic [31:0] tag);
      flow_t e;
      e          = '0;
      e.v        = v;
      e.src_ip   = tag;
      e.dst_ip   = ~tag;
      e.src_port = tag[15:0];
      e.dst_port = tag[31:16];
      e.proto    = 8'h11;
      e.flags    = tag[7:0];
      e.first_ts = last - 32'd10;
      e.last_ts  = last;
      e.pkts     = tag + 32'd1;
      e.bytes    = tag * 32'd3;
      return e;
   endfunction

   logic [32:0] exp_q [$];

   task automatic expect_record(input flow_t f);
      for (int k = 0; k < 8; k++) exp_q.push_back(exp_word(f, k));
   endtask

   // ---------------- compare process ----------------
   int          hs_cnt    = 0;
   int          stall_cnt = 0;
   bit          stalled   = 1'b0;
   logic [32:0] held;

   always @(negedge ACLK) begin
      if (!ARESETN) begin
         stalled = 1'b0;
      end else if (axis.tvalid) begin
         if (stalled) check("stall_hold", 64'({axis.tlast, axis.tdata}), 64'(held));
         if (axis.tready) begin
            if (exp_q.size() == 0) fail_now("unexpected_word", 64'({axis.tlast, axis.tdata}));
            else check("word", 64'({axis.tlast, axis.tdata}), 64'(exp_q.pop_front()));
            hs_cnt++;
            stalled = 1'b0;
         end else begin
            stall_cnt++;
            stalled = 1'b1;
            held    = {axis.tlast, axis.tdata};
         end
      end else begin
         if (stalled) fail_now("tvalid_dropped", 64'd0);
         stalled = 1'b0;
      end
   end

   // BRAM access / ok pulse monitor.
   logic [12:0] acc_q [$];
   int          ok_cnt  = 0;
   bit          ok_prev = 1'b0;

   always @(posedge ACLK) begin
      if (ARESETN && enb) begin
         acc_q.push_back({web, addrb});
         if (web) check("dib_zero", 64'(|dib), 64'd0);
      end
      if (ARESETN && flow_exported_ok) begin
         ok_cnt++;
         if (ok_prev) fail_now("ok_wide", 64'd1);
      end
      ok_prev = ARESETN && flow_exported_ok;
   end

   function automatic int find_acc(input int b, input logic [12:0] val);
      for (int i = b; i < acc_q.size(); i++) if (acc_q[i] == val) return i;
      return -1;
   endfunction

   function automatic int writes_from(input int b);
      int n = 0;
      for (int i = b; i < acc_q.size(); i++) if (acc_q[i][12]) n++;
      return n;
   endfunction

   task automatic wait_ok();
      int cyc = 0;
      while (!flow_exported_ok && cyc < 300) begin
         @(negedge ACLK);
         cyc++;
      end
      check("ok_seen", 64'(flow_exported_ok), 64'd1);
      @(posedge ACLK);
      #1 export_now = 1'b0;
   endtask

   // Latency from request (or reset release) to first tvalid, then wait for ok.
   task automatic serve_request();
      int cyc  = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 50) begin
         @(posedge ACLK);
         cyc++;
         #1 seen = axis.tvalid;
      end
      check("first_tvalid_latency", 64'(cyc), 64'd4);
      wait_ok();
   endtask

   flow_t kn, kb, e, zero_f;
   int    base, hs0, s0, cyc, iw, ir;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESETN      = 1'b0;
      export_now   = 1'b1;
      export_this  = 12'h0A5;
      sweep_enable = 1'b0;
      current_time = 32'd0;
      toggle_mode  = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 241'b0;

      kn = '0;
      kn.v = 1'b1; kn.src_ip = 32'hC0A8_0001; kn.dst_ip = 32'h0A00_0002;
      kn.src_port = 16'h1234; kn.dst_port = 16'h0050; kn.proto = 8'h06; kn.flags = 8'h12;
      kn.first_ts = 32'h0000_1000; kn.last_ts = 32'h0000_2000;
      kn.pkts = 32'h0000_000A; kn.bytes = 32'h0000_0BB8;
      mem[12'h0A5] = kn;

      // pin the model with hand-computed values
      check("pin_w0", 64'(exp_word(kn, 0)), 64'h0_C0A8_0001);
      check("pin_w2", 64'(exp_word(kn, 2)), 64'h0_1234_0050);
      check("pin_w3", 64'(exp_word(kn, 3)), 64'h0_0612_0000);
      check("pin_w7", 64'(exp_word(kn, 7)), 64'h1_0000_0BB8);
      check("pin_entry_msb", 64'(mem[12'h0A5][240:208]), 64'h1_C0A8_0001);
      check("pin_exp_20000", 64'(model_exports(mk_flow(1'b1, 32'd4000, 32'd0), 32'd20000)), 64'd1);
      check("pin_exp_wrap", 64'(model_exports(mk_flow(1'b1, 32'hFFFF_FF00, 32'd0), 32'h100)), 64'd0);
      check("pin_exp_eq", 64'(model_exports(mk_flow(1'b1, 32'h100 - 32'd15000, 32'd0), 32'h100)), 64'd0);

      // 1: reset with export_now held high
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         check("rst_enb", 64'(enb), 64'd0);
      end
      check("rst_web", 64'(web), 64'd0);
      check("rst_addrb", 64'(addrb), 64'd0);
      check("rst_tvalid", 64'(axis.tvalid), 64'd0);
      check("rst_tdata", 64'(axis.tdata), 64'd0);
      check("rst_tlast", 64'(axis.tlast), 64'd0);
      check("rst_ok", 64'(flow_exported_ok), 64'd0);
      check("rst_cnt", 64'(exported_flow_counter), 64'd0);

      // 2: request for 0x0A5 released straight out of reset
      base = acc_q.size();
      hs0  = hs_cnt;
      expect_record(kn);
      @(posedge ACLK);
      #1 ARESETN = 1'b1;
      serve_request();
      repeat (3) @(negedge ACLK);
      check("t2_hs", 64'(hs_cnt - hs0), 64'd8);
      check("t2_q_empty", 64'(exp_q.size()), 64'd0);
      check("t2_acc_n", 64'(acc_q.size() - base), 64'd2);
      check("t2_rd", 64'(acc_q[base]), 64'({1'b0, 12'h0A5}));
      check("t2_wr", 64'(acc_q[base + 1]), 64'({1'b1, 12'h0A5}));
      check("t2_cleared", 64'(mem[12'h0A5] == 241'b0), 64'd1);
      check("t2_ok_cnt", 64'(ok_cnt), 64'd1);
      check("t2_cnt", 64'(exported_flow_counter), 64'd1);

      // 3: request with tready toggling every cycle
      kb = mk_flow(1'b1, 32'h0000_7777, 32'hDEAD_BEEF);
      mem[12'h7FF] = kb;
      base = acc_q.size();
      hs0  = hs_cnt;
      s0   = stall_cnt;
      expect_record(kb);
      toggle_mode = 1'b1;
      @(posedge ACLK);
      #1;
      export_now  = 1'b1;
      export_this = 12'h7FF;
      serve_request();
      toggle_mode = 1'b0;
      repeat (3) @(negedge ACLK);
      check("t3_hs", 64'(hs_cnt - hs0), 64'd8);
      check("t3_stalls", 64'(stall_cnt > s0), 64'd1);
      check("t3_q_empty", 64'(exp_q.size()), 64'd0);
      check("t3_wr", 64'(acc_q[base + 1]), 64'({1'b1, 12'h7FF}));
      check("t3_cleared", 64'(mem[12'h7FF] == 241'b0), 64'd1);
      check("t3_ok_cnt", 64'(ok_cnt), 64'd2);
      check("t3_cnt", 64'(exported_flow_counter), 64'd2);

      // 4: sweep, entries 0-2 invalid, entry 3 expired
      current_time = 32'd20000;
      mem[1] = mk_flow(1'b0, 32'd0, 32'h0000_0101);
      e      = mk_flow(1'b1, 32'd4000, 32'h0303_0303);
      mem[3] = e;
      base = acc_q.size();
      expect_record(e);
      @(posedge ACLK);
      #1 sweep_enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge ACLK);
         cyc++;
      end while (!(enb && web) && cyc < 300);
      sweep_enable = 1'b0;
      repeat (4) @(negedge ACLK);
      check("t4_acc_n", 64'(acc_q.size() - base), 64'd5);
      for (int i = 0; i < 4; i++) check("t4_rd_seq", 64'(acc_q[base + i]), 64'({1'b0, 12'(i)}));
      check("t4_wr", 64'(acc_q[base + 4]), 64'({1'b1, 12'd3}));
      check("t4_cleared", 64'(mem[3] == 241'b0), 64'd1);
      check("t4_invalid_kept", 64'(mem[1] == 241'(mk_flow(1'b0, 32'd0, 32'h0000_0101))), 64'd1);
      check("t4_no_ok", 64'(ok_cnt), 64'd2);
      check("t4_cnt", 64'(exported_flow_counter), 64'd3);
      check("t4_q_empty", 64'(exp_q.size()), 64'd0);

      // 5: wrap-safe age, timeout boundary, pointer wrap 4095 -> 0
      current_time = 32'h0000_0100;
      mem[10]   = mk_flow(1'b1, 32'hFFFF_FF00, 32'h0000_0A0A);
      mem[20]   = mk_flow(1'b1, 32'h100 - 32'd15000, 32'h0000_1414);
      e         = mk_flow(1'b1, 32'h100 - 32'd15001, 32'h0000_1515);
      mem[21]   = e;
      mem[4095] = mk_flow(1'b1, 32'hFFFF_FF00, 32'h0000_0FFF);
      base = acc_q.size();
      expect_record(e);
      @(posedge ACLK);
      #1 sweep_enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge ACLK);
         cyc++;
      end while (!(acc_q.size() > base && acc_q[acc_q.size() - 1] == 13'h0000) && cyc < 20000);
      sweep_enable = 1'b0;
      repeat (6) @(negedge ACLK);
      check("t5_first_rd", 64'(acc_q[base]), 64'({1'b0, 12'd4}));
      check("t5_wrap_prev", 64'(acc_q[acc_q.size() - 2]), 64'({1'b0, 12'hFFF}));
      check("t5_wrap_last", 64'(acc_q[acc_q.size() - 1]), 64'({1'b0, 12'h000}));
      check("t5_writes", 64'(writes_from(base)), 64'd1);
      check("t5_wr21", 64'(find_acc(base, {1'b1, 12'd21}) >= 0), 64'd1);
      check("t5_keep10", 64'(mem[10][240]), 64'd1);
      check("t5_keep20", 64'(mem[20][240]), 64'd1);
      check("t5_keep4095", 64'(mem[4095][240]), 64'd1);
      check("t5_cleared21", 64'(mem[21] == 241'b0), 64'd1);
      check("t5_cnt", 64'(exported_flow_counter), 64'd4);
      check("t5_q_empty", 64'(exp_q.size()), 64'd0);

      // 6: request raised during a sweep SEND; invalid request entry still sent
      e       = mk_flow(1'b1, 32'hFFFF_0000, 32'h0000_3232);
      mem[50] = e;
      zero_f  = '0;
      mem[12'h300] = zero_f;
      base = acc_q.size();
      expect_record(e);
      expect_record(zero_f);
      @(posedge ACLK);
      #1 sweep_enable = 1'b1;
      cyc = 0;
      do begin
         @(negedge ACLK);
         cyc++;
      end while (!axis.tvalid && cyc < 1000);
      export_now  = 1'b1;
      export_this = 12'h300;
      wait_ok();
      sweep_enable = 1'b0;
      repeat (4) @(negedge ACLK);
      iw = find_acc(base, {1'b1, 12'd50});
      ir = find_acc(base, {1'b0, 12'h300});
      check("t6_w50_found", 64'(iw >= 0), 64'd1);
      check("t6_req_next", 64'(ir - iw), 64'd1);
      check("t6_cleared50", 64'(mem[50] == 241'b0), 64'd1);
      check("t6_ok_cnt", 64'(ok_cnt), 64'd3);
      check("t6_cnt", 64'(exported_flow_counter), 64'd6);
      check("t6_q_empty", 64'(exp_q.size()), 64'd0);

      // 7: reset in the middle of a sweep record
      e       = mk_flow(1'b1, 32'hFFFF_0000, 32'h0000_3C3C);
      mem[60] = e;
      base = acc_q.size();
      hs0  = hs_cnt;
      expect_record(e);
      @(posedge ACLK);
      #1 sweep_enable = 1'b1;
      cyc = 0;
      do begin
         @(posedge ACLK);
         #2 cyc++;
      end while ((hs_cnt - hs0) < 3 && cyc < 500);
      ARESETN      = 1'b0;
      sweep_enable = 1'b0;
      #1;
      check("t7_tvalid_drop", 64'(axis.tvalid), 64'd0);
      check("t7_cnt_rst", 64'(exported_flow_counter), 64'd0);
      check("t7_enb_rst", 64'(enb), 64'd0);
      exp_q.delete();
      repeat (3) @(negedge ACLK);
      check("t7_hs", 64'(hs_cnt - hs0), 64'd3);
      check("t7_no_write", 64'(writes_from(base)), 64'd0);
      check("t7_entry_valid", 64'(mem[60][240]), 64'd1);
      check("t7_no_ok", 64'(ok_cnt), 64'd3);
      @(posedge ACLK);
      #1 ARESETN = 1'b1;
      base = acc_q.size();
      repeat (5) @(negedge ACLK);
      check("t7_idle_tvalid", 64'(axis.tvalid), 64'd0);
      check("t7_idle_acc", 64'(acc_q.size() - base), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
